warp_scheduler: RTL
===================

Name: warp_scheduler

Overview:
- Selects which warp of a core owns the shared fetch/decode/execute datapath each cycle; drives the per-warp state store's warp select and per-warp resets.
- Hides memory latency: switches away from a warp with an outstanding LSU request, with optional time-slice fairness.
- Sits between the core's block dispatch handshake and the per-warp state store.

Parameters:
- NUM_WARPS, 2, warps per core; legal range 2..8.
- WARP_BITS, $clog2(NUM_WARPS), width of warp_select.
- QUANTUM, 16, maximum consecutive RUN cycles for one warp while another is eligible; 0 disables time-slicing.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  launch block; sampled in IDLE and DONE only.
- warp_enable  input  NUM_WARPS  warps holding live threads for this block; sampled in LAUNCH.
- warp_done  input  NUM_WARPS  one-cycle pulse: warp executed RET.
- warp_mem_pending  input  NUM_WARPS  level: warp has an outstanding LSU request.
- warp_boundary  input  1  active warp is at an instruction boundary (FETCH about to begin).
- warp_select  output  WARP_BITS  index of the warp owning the datapath.
- issue_valid  output  1  datapath may advance the selected warp.
- warp_reset  output  NUM_WARPS  one-cycle per-warp reset pulse.
- finished  output  NUM_WARPS  retired-warp mask.
- done  output  1  all enabled warps retired.

Behaviour:
- Reset: state=IDLE; warp_select=0, issue_valid=0, warp_reset=0, finished=0, done=0, quantum counter=0. Reset mid-operation aborts immediately; no warp_reset pulse is generated by reset itself.
- States: IDLE, LAUNCH, RUN, SWITCH, DONE. All outputs are registered.
- IDLE:
  - All outputs 0.
  - start=1 -> LAUNCH.
- LAUNCH (1 cycle):
  - warp_reset = warp_enable; finished <= ~warp_enable (disabled warps count as retired).
  - warp_select <= lowest enabled index.
  - warp_enable==0 -> DONE; else -> RUN.
- eligible[i] = ~finished[i] & ~warp_mem_pending[i].
- RUN:
  - issue_valid=1; quantum counter increments each cycle and saturates at QUANTUM.
  - Evaluate in priority order:
    1. warp_done[warp_select]: set finished bit. If all bits are now set -> DONE; else -> SWITCH.
    2. warp_boundary & warp_mem_pending[active] & another eligible warp exists -> SWITCH.
    3. warp_boundary & QUANTUM!=0 & counter>=QUANTUM & another eligible warp exists -> SWITCH.
    4. Otherwise stay in RUN.
  - warp_done bits on non-selected warps set their finished bits in any state except IDLE and LAUNCH; they do not cause a state change unless that makes all bits set, in which case the FSM goes to DONE.
- SWITCH:
  - issue_valid=0 (one-cycle bubble minimum).
  - Next warp is the round-robin search from warp_select+1, wrapping modulo NUM_WARPS, with the current warp checked last. First eligible warp -> warp_select, counter cleared, -> RUN.
  - No eligible warp (all unfinished warps pending): stay in SWITCH and re-search every cycle.
  - All warps finished -> DONE.
- DONE:
  - done=1, issue_valid=0, finished held.
  - start=1 -> LAUNCH (relaunch); finished is re-initialised there.
- start outside IDLE/DONE is ignored.
- warp_select changes only on the SWITCH->RUN transition or in LAUNCH. It is stable whenever issue_valid=1.
- Time-slice and memory-yield switches occur only when warp_boundary=1. Switching never occurs mid-instruction.

Test Plan:
- NUM_WARPS=2, warp_enable=2'b11, start -> LAUNCH pulses warp_reset=2'b11; next cycle RUN, warp_select=0, issue_valid=1.
- Warp0 at boundary with mem_pending[0]=1, warp1 eligible -> one bubble cycle (issue_valid=0), then warp_select=1; with mem_pending[1]=1 as well, the FSM stays in SWITCH until one clears.
- QUANTUM=4, no pending, warp_boundary=1 -> warp_select toggles 0,1,0 every 4 RUN cycles plus one bubble; with warp_enable=2'b01, warp 0 is never switched out.
- warp_done[0] pulse then warp_done[1] pulse -> finished=2'b01 then 2'b11, done=1 one cycle after the second pulse; start then relaunches with finished cleared.
- warp_enable=0, start -> LAUNCH then DONE, done=1, issue_valid never asserted.
- reset asserted during RUN with warp_select=1 -> next cycle IDLE, all outputs 0, finished=0.

Source files
------------

// File: rtl/warp_scheduler.sv
// Warp scheduler: picks the warp that owns the shared datapath each cycle,
// yielding on outstanding LSU requests and on time-slice expiry at boundaries.
module warp_scheduler #(
    parameter int NUM_WARPS = 2,
    parameter int WARP_BITS = $clog2(NUM_WARPS),
    parameter int QUANTUM   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_WARPS-1:0] warp_enable,
    input  logic [NUM_WARPS-1:0] warp_done,
    input  logic [NUM_WARPS-1:0] warp_mem_pending,
    input  logic                 warp_boundary,
    output logic [WARP_BITS-1:0] warp_select,
    output logic                 issue_valid,
    output logic [NUM_WARPS-1:0] warp_reset,
    output logic [NUM_WARPS-1:0] finished,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_SWITCH,
        S_DONE
    } state_t;

    localparam int CW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
    localparam logic [CW-1:0] QMAX = CW'(QUANTUM);

    state_t               state_q;
    logic [WARP_BITS-1:0] sel_q;
    logic                 valid_q;
    logic [NUM_WARPS-1:0] wrst_q;
    logic [NUM_WARPS-1:0] fin_q;
    logic                 done_q;
    logic [CW-1:0]        cnt_q;

    logic [NUM_WARPS-1:0] fin_d;
    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] sel_mask;
    logic                 other_elig;
    logic                 all_fin;
    logic [CW-1:0]        cnt_inc;
    logic                 time_up;
    logic                 found;
    logic [WARP_BITS-1:0] nxt;
    logic [WARP_BITS-1:0] cand;
    logic [WARP_BITS-1:0] first_en;
    logic                 launch;
    logic                 yield;

    always_comb begin
        fin_d      = fin_q | warp_done;
        elig       = ~fin_d & ~warp_mem_pending;
        sel_mask   = '0;
        sel_mask[sel_q] = 1'b1;
        other_elig = |(elig & ~sel_mask);
        all_fin    = &fin_d;
        cnt_inc    = (cnt_q == QMAX) ? cnt_q : cnt_q + 1'b1;
        time_up    = (QUANTUM != 0) && (cnt_inc >= QMAX);
        yield      = warp_boundary && other_elig &&
                     (warp_mem_pending[sel_q] || time_up);
        launch     = start && (state_q == S_IDLE || state_q == S_DONE);

        // Round-robin from sel+1; the current warp comes up last.
        found = 1'b0;
        nxt   = sel_q;
        cand  = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            cand = WARP_BITS'((int'(sel_q) + k) % NUM_WARPS);
            if (!found && elig[cand]) begin
                found = 1'b1;
                nxt   = cand;
            end
        end

        first_en = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (warp_enable[i]) first_en = WARP_BITS'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrst_q  <= '0;
            fin_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wrst_q <= '0;
            if (launch) begin
                // Outputs reflect LAUNCH while the FSM sits in it.
                state_q <= S_LAUNCH;
                wrst_q  <= warp_enable;
                fin_q   <= ~warp_enable;
                sel_q   <= first_en;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    S_LAUNCH: begin
                        cnt_q <= '0;
                        if (&fin_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            valid_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        fin_q <= fin_d;
                        cnt_q <= cnt_inc;
                        if (all_fin) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (warp_done[sel_q] || yield) begin
                            state_q <= S_SWITCH;
                            valid_q <= 1'b0;
                        end
                    end
                    S_SWITCH: begin
                        fin_q <= fin_d;
                        if (all_fin) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (found) begin
                            state_q <= S_RUN;
                            sel_q   <= nxt;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        fin_q <= fin_d;
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign warp_select = sel_q;
    assign issue_valid = valid_q;
    assign warp_reset  = wrst_q;
    assign finished    = fin_q;
    assign done        = done_q;

endmodule
